// File: rtl/grass_pkg.sv
// Shared defaults, FSM state encoding and per-layer config record for the grass sway scheduler.
package grass_pkg;
   localparam int DEF_NUM_LAYERS = 4;
   localparam int DEF_OFS_W      = 6;
   localparam int DEF_DIV_W      = 4;
   localparam int DEF_AMP_RST    = 31;
   localparam int LAYER_W        = 2;

   typedef enum logic [1:0] {IDLE, COMMIT, UPD, PUBLISH} state_e;

   typedef struct packed {
      logic [DEF_OFS_W-1:0] amp;
      logic [DEF_DIV_W-1:0] div;
      logic                 en;
   } layer_cfg_t;
endpackage

// File: rtl/grass_sway_scheduler_if.sv
// Per-layer configuration write channel (valid/ready) into the sway scheduler.
interface grass_sway_scheduler_if;
   import grass_pkg::*;

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [LAYER_W-1:0]   cfg_layer;
   logic [DEF_OFS_W-1:0] cfg_amp;
   logic [DEF_DIV_W-1:0] cfg_div;
   logic                 cfg_en;

   modport master (output cfg_valid, cfg_layer, cfg_amp, cfg_div, cfg_en, input cfg_ready);
   modport slave  (input cfg_valid, cfg_layer, cfg_amp, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/grass_layer_step.sv
// Combinational next state of one blade layer for a single frame: divider count and ping-pong step.
module grass_layer_step
   import grass_pkg::*;
(
   input  logic [DEF_OFS_W-1:0] offset_i,
   input  logic                 dir_i,
   input  logic [DEF_DIV_W-1:0] div_cnt_i,
   input  layer_cfg_t           cfg_i,
   input  logic                 skip_i,
   output logic [DEF_OFS_W-1:0] offset_o,
   output logic                 dir_o,
   output logic [DEF_DIV_W-1:0] div_cnt_o
);

   always_comb begin
      offset_o  = offset_i;
      dir_o     = dir_i;
      div_cnt_o = div_cnt_i;
      if (!skip_i && cfg_i.en) begin
         if (div_cnt_i != cfg_i.div) begin
            div_cnt_o = div_cnt_i + 1'b1;
         end else begin
            div_cnt_o = '0;
            // Turning points reverse and move in one frame; amp==0 pins the offset at zero.
            if (dir_i) begin
               if (offset_i < cfg_i.amp) begin
                  offset_o = offset_i + 1'b1;
               end else begin
                  dir_o = 1'b0;
                  if (offset_i != '0) offset_o = offset_i - 1'b1;
               end
            end else begin
               if (offset_i != '0) begin
                  offset_o = offset_i - 1'b1;
               end else begin
                  dir_o = 1'b1;
                  if (cfg_i.amp != '0) offset_o = offset_i + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/grass_sway_scheduler.sv
// Frame-synchronous sway sequencer: on each vsync rising edge it commits staged config,
// steps every layer in turn and publishes offsets/dirs/scroll as tear-free shadow registers.
module grass_sway_scheduler
   import grass_pkg::*;
#(
   parameter int NUM_LAYERS = DEF_NUM_LAYERS,
   parameter int OFS_W      = DEF_OFS_W,
   parameter int DIV_W      = DEF_DIV_W,
   parameter int AMP_RST    = DEF_AMP_RST
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        vsync,
   input  logic                        pause,
   grass_sway_scheduler_if.slave       cfg,
   output logic                        frame_tick,
   output logic [NUM_LAYERS*OFS_W-1:0] offset,
   output logic [NUM_LAYERS-1:0]       dir,
   output logic [9:0]                  scroll
);

   localparam int IDX_W = $clog2(NUM_LAYERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

   state_e                 state_q, state_d;
   logic                   vsync_q, frame_tick_q, pause_f_q;
   logic [IDX_W-1:0]       idx_q;
   logic [9:0]             scroll_q;
   logic [NUM_LAYERS-1:0]  pend_q, dir_q, pub_dir_q;
   logic [OFS_W-1:0]       off_q     [NUM_LAYERS];
   logic [OFS_W-1:0]       pub_off_q [NUM_LAYERS];
   logic [DIV_W-1:0]       cnt_q     [NUM_LAYERS];
   layer_cfg_t             cfg_q     [NUM_LAYERS];
   layer_cfg_t             stage_q   [NUM_LAYERS];

   logic             vs_edge, accept;
   logic [OFS_W-1:0] step_off;
   logic             step_dir;
   logic [DIV_W-1:0] step_cnt;

   assign vs_edge       = vsync & ~vsync_q;
   assign cfg.cfg_ready = (state_q == IDLE);
   assign accept        = cfg.cfg_valid & cfg.cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vs_edge) state_d = COMMIT;
         COMMIT:  state_d = UPD;
         UPD:     if (idx_q == LAST_IDX) state_d = PUBLISH;
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One shared stepper, steered to the layer currently being swept.
   grass_layer_step u_step (
      .offset_i  (off_q[idx_q]),
      .dir_i     (dir_q[idx_q]),
      .div_cnt_i (cnt_q[idx_q]),
      .cfg_i     (cfg_q[idx_q]),
      .skip_i    (pause_f_q),
      .offset_o  (step_off),
      .dir_o     (step_dir),
      .div_cnt_o (step_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q      <= 1'b0;
         frame_tick_q <= 1'b0;
         pause_f_q    <= 1'b0;
         idx_q        <= '0;
         scroll_q     <= '0;
         pend_q       <= '0;
         dir_q        <= '1;
         pub_dir_q    <= '1;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            off_q[i]     <= '0;
            pub_off_q[i] <= '0;
            cnt_q[i]     <= '0;
            cfg_q[i]     <= '{amp: DEF_OFS_W'(AMP_RST), div: '0, en: 1'b1};
            stage_q[i]   <= '{amp: DEF_OFS_W'(AMP_RST), div: '0, en: 1'b1};
         end
      end else begin
         vsync_q      <= vsync;
         frame_tick_q <= (state_q == IDLE) && vs_edge;
         if (accept) begin
            stage_q[cfg.cfg_layer] <= '{amp: cfg.cfg_amp, div: cfg.cfg_div, en: cfg.cfg_en};
            pend_q[cfg.cfg_layer]  <= 1'b1;
         end
         case (state_q)
            COMMIT: begin
               for (int i = 0; i < NUM_LAYERS; i++) begin
                  if (pend_q[i]) begin
                     cfg_q[i] <= stage_q[i];
                     cnt_q[i] <= '0;
                     if (off_q[i] > stage_q[i].amp) begin
                        off_q[i] <= stage_q[i].amp;
                        dir_q[i] <= 1'b0;
                     end
                  end
               end
               pend_q    <= '0;
               pause_f_q <= pause;
               idx_q     <= '0;
            end
            UPD: begin
               off_q[idx_q] <= step_off;
               dir_q[idx_q] <= step_dir;
               cnt_q[idx_q] <= step_cnt;
               idx_q        <= idx_q + 1'b1;
            end
            PUBLISH: begin
               pub_off_q <= off_q;
               pub_dir_q <= dir_q;
               if (!pause_f_q) scroll_q <= scroll_q + 10'd1;
            end
            default: ;
         endcase
      end
   end

   assign frame_tick = frame_tick_q;
   assign dir        = pub_dir_q;
   assign scroll     = scroll_q;

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pub
      assign offset[g*OFS_W +: OFS_W] = pub_off_q[g];
   end

endmodule
